// File: rtl/shared_mem_arbiter.sv
// ---------------------------------------------------------------------------
// shared_mem_arbiter
//   N-port shared data memory with an integrated arbiter. One access is
//   served per clock. Each port has a valid/ready request channel. All ports
//   share one registered response: a one-hot resp_valid pulse arrives one
//   cycle after the transfer edge, and carries shared rdata/err.
//
// Ports
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   req_valid_i    per-port request present
//   req_ready_o    per-port grant (transfer on edge where valid & ready)
//   req_write_i    per-port 1 = write, 0 = read
//   req_addr_i     per-port byte address
//   req_wdata_i    per-port write data
//   req_wstrb_i    per-port byte enables
//   resp_valid_o   one-hot response pulse, one cycle after the transfer
//   resp_rdata_o   read data (old word for writes), qualified by resp_valid_o
//   resp_err_o     address out of range, qualified by resp_valid_o
//   grant_id_o     index of the port granted this cycle, 0 when none
// ---------------------------------------------------------------------------
module shared_mem_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_SIZE   = 1024,
  parameter int ARB_MODE   = 0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_n_i,
  input  logic [NUM_PORTS-1:0]                     req_valid_i,
  output logic [NUM_PORTS-1:0]                     req_ready_o,
  input  logic [NUM_PORTS-1:0]                     req_write_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   req_wstrb_i,
  output logic [NUM_PORTS-1:0]                     resp_valid_o,
  output logic [DATA_WIDTH-1:0]                    resp_rdata_o,
  output logic                                     resp_err_o,
  output logic [$clog2(NUM_PORTS)-1:0]             grant_id_o
);

  localparam int ID_W   = $clog2(NUM_PORTS);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(STRB_W);
  localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  // Control state
  logic [ID_W-1:0]              last_grant_q, last_grant_d;
  logic                         active_q;

  // Response registers
  logic [NUM_PORTS-1:0]         resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]        resp_rdata_q, resp_rdata_d;
  logic                         resp_err_q, resp_err_d;

  // Storage (never reset)
  logic [DATA_WIDTH-1:0]        mem_q [MEM_SIZE];

  // Arbitration results
  logic                         gnt_found;
  logic [ID_W-1:0]              gnt_idx;
  logic                         xfer;

  // Selected request fields
  logic                         sel_write;
  logic [ADDR_WIDTH-1:0]        sel_addr;
  logic [ADDR_WIDTH-1:0]        sel_word;
  logic [DATA_WIDTH-1:0]        sel_wdata;
  logic [STRB_W-1:0]            sel_wstrb;
  logic                         in_range;
  logic [MEM_AW-1:0]            mem_idx;
  logic [DATA_WIDTH-1:0]        old_word;

  // ---- Stage 0: arbitration (combinational) ------------------------------
  // Round-robin scans last_grant+1 .. last_grant+NUM_PORTS; iterating the
  // offsets downward lets the nearest valid port overwrite farther ones.
  always_comb begin : arbitrate
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_valid_i[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_W'(i);
        end
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        cand = (int'(last_grant_q) + k) % NUM_PORTS;
        if (req_valid_i[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_W'(cand);
        end
      end
    end
  end

  // active_q is cleared asynchronously by reset and set on the first edge
  // after release, so grants are blocked throughout reset without routing
  // the async reset net into synchronous logic.
  assign xfer = gnt_found & active_q;

  always_comb begin : ready_decode
    req_ready_o = '0;
    if (xfer) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign grant_id_o = xfer ? gnt_idx : '0;

  // Request mux and address decode
  assign sel_write = req_write_i[gnt_idx];
  assign sel_addr  = req_addr_i[gnt_idx];
  assign sel_wdata = req_wdata_i[gnt_idx];
  assign sel_wstrb = req_wstrb_i[gnt_idx];

  // Full-width word index: any set upper bit pushes it past MEM_SIZE, so a
  // single compare covers both the depth check and discarded upper bits.
  assign sel_word = sel_addr >> OFFS_W;
  assign in_range = (sel_word < ADDR_WIDTH'(MEM_SIZE));
  assign mem_idx  = sel_word[MEM_AW-1:0];

  // Pre-edge contents give read-before-write semantics for writes.
  assign old_word = in_range ? mem_q[mem_idx] : '0;

  always_comb begin : next_state
    last_grant_d = last_grant_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (xfer) begin
      if (ARB_MODE == 0) begin
        last_grant_d = gnt_idx;
      end
      resp_valid_d[gnt_idx] = 1'b1;
      resp_rdata_d          = old_word;
      resp_err_d            = ~in_range;
    end
  end

  // ---- Stage 1: transfer edge -> memory update and response registers ----
  always_ff @(posedge clk_i) begin : mem_write
    if (xfer && sel_write && in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (sel_wstrb[b]) begin
          mem_q[mem_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin : ctrl_regs
    if (!rst_n_i) begin
      active_q     <= 1'b0;
      last_grant_q <= ID_W'(NUM_PORTS - 1);
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      active_q     <= 1'b1;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
module tb_shared_mem_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_write;
  logic [3:0][63:0] req_addr;
  logic [3:0][63:0] req_wdata;
  logic [3:0][7:0]  req_wstrb;

  logic [3:0]       rr_ready, rr_rvalid;
  logic [63:0]      rr_rdata;
  logic             rr_err;
  logic [1:0]       rr_gid;

  logic [3:0]       fp_ready, fp_rvalid;
  logic [63:0]      fp_rdata;
  logic             fp_err;
  logic [1:0]       fp_gid;

  int total = 0;
  int bad   = 0;

  shared_mem_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(64), .ADDR_WIDTH(64), .MEM_SIZE(1024), .ARB_MODE(0)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(rr_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(rr_rvalid), .resp_rdata_o(rr_rdata), .resp_err_o(rr_err),
    .grant_id_o(rr_gid)
  );

  shared_mem_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(64), .ADDR_WIDTH(64), .MEM_SIZE(1024), .ARB_MODE(1)
  ) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(fp_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(fp_rvalid), .resp_rdata_o(fp_rdata), .resp_err_o(fp_err),
    .grant_id_o(fp_gid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic wr, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    req_write[p] = wr;
    req_addr[p]  = a;
    req_wdata[p] = d;
    req_wstrb[p] = s;
    req_valid[p] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_write = 4'b0000;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (rr_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", rr_ready); end
    total++; if (fp_ready !== 4'b0000) begin bad++; $display("FAIL reset_fp_ready: got %b want 0000", fp_ready); end
    total++; if (rr_rvalid !== 4'b0000) begin bad++; $display("FAIL reset_rvalid: got %b want 0000", rr_rvalid); end
    total++; if (rr_rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rr_rdata); end
    total++; if (rr_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", rr_err); end
    total++; if (rr_gid !== 2'd0) begin bad++; $display("FAIL reset_gid: got %0d want 0", rr_gid); end
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    step();
  endtask

  // Every port holds valid for two reads; order must rotate 0,1,2,3,0,1,2,3.
  task automatic test_rr_fairness();
    int cnt [4];
    int exp;
    for (int p = 0; p < 4; p++) begin
      cnt[p] = 0;
      drive(p, 1'b0, 64'h0, 64'h0, 8'h00);
    end
    for (int c = 0; c < 8; c++) begin
      exp = c % 4;
      @(negedge clk);
      total++; if (rr_ready !== (4'b0001 << exp)) begin bad++; $display("FAIL rr_fair_ready[%0d]: got %b want %b", c, rr_ready, 4'b0001 << exp); end
      total++; if (rr_gid !== 2'(exp)) begin bad++; $display("FAIL rr_fair_gid[%0d]: got %0d want %0d", c, rr_gid, exp); end
      step();
      total++; if (rr_rvalid !== (4'b0001 << exp)) begin bad++; $display("FAIL rr_fair_rvalid[%0d]: got %b want %b", c, rr_rvalid, 4'b0001 << exp); end
      total++; if (rr_err !== 1'b0) begin bad++; $display("FAIL rr_fair_err[%0d]: got %b want 0", c, rr_err); end
      cnt[exp]++;
      if (cnt[exp] == 2) req_valid[exp] = 1'b0;
    end
    @(negedge clk);
    total++; if (rr_ready !== 4'b0000) begin bad++; $display("FAIL rr_fair_idle_ready: got %b want 0000", rr_ready); end
    step();
    total++; if (rr_rvalid !== 4'b0000) begin bad++; $display("FAIL rr_fair_idle_rvalid: got %b want 0000", rr_rvalid); end
  endtask

  task automatic test_single_port();
    drive(0, 1'b1, 64'h40, 64'h1122334455667788, 8'hFF);
    @(negedge clk);
    total++; if (rr_ready !== 4'b0001) begin bad++; $display("FAIL sp_wr_ready: got %b want 0001", rr_ready); end
    step();
    total++; if (rr_rvalid !== 4'b0001) begin bad++; $display("FAIL sp_wr_rvalid: got %b want 0001", rr_rvalid); end
    total++; if (rr_err !== 1'b0) begin bad++; $display("FAIL sp_wr_err: got %b want 0", rr_err); end
    req_write[0] = 1'b0;
    @(negedge clk);
    total++; if (rr_ready !== 4'b0001) begin bad++; $display("FAIL sp_rd_ready: got %b want 0001", rr_ready); end
    step();
    total++; if (rr_rvalid !== 4'b0001) begin bad++; $display("FAIL sp_rd_rvalid: got %b want 0001", rr_rvalid); end
    total++; if (rr_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL sp_rd_rdata: got %h want 1122334455667788", rr_rdata); end
    total++; if (rr_err !== 1'b0) begin bad++; $display("FAIL sp_rd_err: got %b want 0", rr_err); end
    req_valid = 4'b0000;
    step();
    total++; if (rr_rvalid !== 4'b0000) begin bad++; $display("FAIL sp_idle_rvalid: got %b want 0000", rr_rvalid); end
    total++; if (rr_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL sp_hold_rdata: got %h want 1122334455667788", rr_rdata); end
  endtask

  // Pointer sits at port 0 here: ports 0 and 2 valid -> 2 then 0; then port 2 alone.
  task automatic test_rr_gaps();
    drive(0, 1'b0, 64'h40, 64'h0, 8'h00);
    drive(2, 1'b0, 64'h40, 64'h0, 8'h00);
    @(negedge clk);
    total++; if (rr_ready !== 4'b0100) begin bad++; $display("FAIL gap_first_ready: got %b want 0100", rr_ready); end
    step();
    total++; if (rr_rvalid !== 4'b0100) begin bad++; $display("FAIL gap_first_rvalid: got %b want 0100", rr_rvalid); end
    total++; if (rr_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL gap_first_rdata: got %h want 1122334455667788", rr_rdata); end
    @(negedge clk);
    total++; if (rr_ready !== 4'b0001) begin bad++; $display("FAIL gap_second_ready: got %b want 0001", rr_ready); end
    step();
    total++; if (rr_rvalid !== 4'b0001) begin bad++; $display("FAIL gap_second_rvalid: got %b want 0001", rr_rvalid); end
    req_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (rr_ready !== 4'b0100) begin bad++; $display("FAIL gap_solo_ready[%0d]: got %b want 0100", c, rr_ready); end
      step();
      total++; if (rr_rvalid !== 4'b0100) begin bad++; $display("FAIL gap_solo_rvalid[%0d]: got %b want 0100", c, rr_rvalid); end
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_strobes();
    drive(1, 1'b1, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    @(negedge clk);
    total++; if (rr_ready !== 4'b0010) begin bad++; $display("FAIL strb_fill_ready: got %b want 0010", rr_ready); end
    step();
    drive(1, 1'b1, 64'h80, 64'h0, 8'h0F);
    step();
    total++; if (rr_rvalid !== 4'b0010) begin bad++; $display("FAIL strb_wr_rvalid: got %b want 0010", rr_rvalid); end
    total++; if (rr_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL strb_wr_oldword: got %h want ffffffffffffffff", rr_rdata); end
    drive(1, 1'b0, 64'h80, 64'h0, 8'h00);
    step();
    total++; if (rr_rdata !== 64'hFFFF_FFFF_0000_0000) begin bad++; $display("FAIL strb_rd_rdata: got %h want ffffffff00000000", rr_rdata); end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_error();
    drive(3, 1'b0, 64'd1024 * 64'd8, 64'h0, 8'h00);
    step();
    total++; if (rr_rvalid !== 4'b1000) begin bad++; $display("FAIL err_oor_rvalid: got %b want 1000", rr_rvalid); end
    total++; if (rr_err !== 1'b1) begin bad++; $display("FAIL err_oor_err: got %b want 1", rr_err); end
    total++; if (rr_rdata !== 64'h0) begin bad++; $display("FAIL err_oor_rdata: got %h want 0", rr_rdata); end
    drive(3, 1'b1, 64'h8000_0000_0000_0040, 64'h0, 8'hFF);
    step();
    total++; if (rr_err !== 1'b1) begin bad++; $display("FAIL err_upper_err: got %b want 1", rr_err); end
    drive(3, 1'b0, 64'h40, 64'h0, 8'h00);
    step();
    total++; if (rr_err !== 1'b0) begin bad++; $display("FAIL err_unchanged_err: got %b want 0", rr_err); end
    total++; if (rr_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL err_unchanged_rdata: got %h want 1122334455667788", rr_rdata); end
    drive(3, 1'b1, 64'h1FF8, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
    step();
    drive(3, 1'b0, 64'h1FF8, 64'h0, 8'h00);
    step();
    total++; if (rr_err !== 1'b0) begin bad++; $display("FAIL err_lastword_err: got %b want 0", rr_err); end
    total++; if (rr_rdata !== 64'hA5A5_5A5A_0F0F_F0F0) begin bad++; $display("FAIL err_lastword_rdata: got %h want a5a55a5a0f0ff0f0", rr_rdata); end
    req_valid = 4'b0000;
    step();
  endtask

  // Fixed-priority instance: ports 1 and 3 each queue three reads.
  task automatic test_fixed_priority();
    int cnt1;
    int cnt3;
    int exp;
    cnt1 = 0;
    cnt3 = 0;
    drive(1, 1'b0, 64'h40, 64'h0, 8'h00);
    drive(3, 1'b0, 64'h40, 64'h0, 8'h00);
    for (int c = 0; c < 6; c++) begin
      exp = (c < 3) ? 1 : 3;
      @(negedge clk);
      total++; if (fp_ready !== (4'b0001 << exp)) begin bad++; $display("FAIL fp_ready[%0d]: got %b want %b", c, fp_ready, 4'b0001 << exp); end
      total++; if (fp_gid !== 2'(exp)) begin bad++; $display("FAIL fp_gid[%0d]: got %0d want %0d", c, fp_gid, exp); end
      step();
      total++; if (fp_rvalid !== (4'b0001 << exp)) begin bad++; $display("FAIL fp_rvalid[%0d]: got %b want %b", c, fp_rvalid, 4'b0001 << exp); end
      total++; if (fp_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL fp_rdata[%0d]: got %h want 1122334455667788", c, fp_rdata); end
      if (exp == 1) begin
        cnt1++;
        if (cnt1 == 3) req_valid[1] = 1'b0;
      end else begin
        cnt3++;
        if (cnt3 == 3) req_valid[3] = 1'b0;
      end
    end
    step();
  endtask

  // Grant port 2 (pointer -> 2), reset in the response cycle, then all valid:
  // a reset pointer must pick port 0 rather than port 3.
  task automatic test_reset_mid();
    req_valid = 4'b0000;
    drive(2, 1'b0, 64'h40, 64'h0, 8'h00);
    @(negedge clk);
    total++; if (rr_ready !== 4'b0100) begin bad++; $display("FAIL rstmid_grant_ready: got %b want 0100", rr_ready); end
    step();
    rst_n = 1'b0;
    #1;
    total++; if (rr_rvalid !== 4'b0000) begin bad++; $display("FAIL rstmid_rvalid: got %b want 0000", rr_rvalid); end
    total++; if (rr_rdata !== 64'h0) begin bad++; $display("FAIL rstmid_rdata: got %h want 0", rr_rdata); end
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 64'h40, 64'h0, 8'h00);
    @(negedge clk);
    total++; if (rr_ready !== 4'b0000) begin bad++; $display("FAIL rstmid_held_ready: got %b want 0000", rr_ready); end
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    total++; if (rr_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_first_ready: got %b want 0001", rr_ready); end
    total++; if (rr_gid !== 2'd0) begin bad++; $display("FAIL rstmid_first_gid: got %0d want 0", rr_gid); end
    step();
    total++; if (rr_rvalid !== 4'b0001) begin bad++; $display("FAIL rstmid_first_rvalid: got %b want 0001", rr_rvalid); end
    req_valid = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_single_port();
    test_rr_gaps();
    test_strobes();
    test_error();
    test_fixed_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Parametrised N-port shared data memory with an integrated arbiter, serving the core cluster.
- Every core gets a valid/ready request channel and a registered response channel.
- Arbitration is selectable between true round-robin (rotating pointer) and fixed priority.
- Adds byte-strobe writes and out-of-range error reporting, and sustains one access per clock.

Parameters:
- NUM_PORTS, 4, number of requesting cores; any value ≥2.
- DATA_WIDTH, 64, word width; a multiple of 8.
- ADDR_WIDTH, 64, byte-address width.
- MEM_SIZE, 1024, depth in words.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [NUM_PORTS]  request present per port.
- req_ready  out  [NUM_PORTS]  grant; the transfer occurs on a clock edge where valid&ready=1.
- req_write  in  [NUM_PORTS]  1 = write, 0 = read.
- req_addr  in  [NUM_PORTS][ADDR_WIDTH]  byte address.
- req_wdata  in  [NUM_PORTS][DATA_WIDTH]  write data.
- req_wstrb  in  [NUM_PORTS][DATA_WIDTH/8]  byte enables.
- resp_valid  out  [NUM_PORTS]  one-cycle response pulse, one-hot.
- resp_rdata  out  [DATA_WIDTH]  read data shared by all ports; qualified by resp_valid.
- resp_err  out  1  address out of range; qualified by resp_valid.
- grant_id  out  $clog2(NUM_PORTS)  index of the port granted in the current cycle; 0 when no grant.

Behaviour:
- Reset
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0 while rst_n=0.
  - Round-robin pointer last_grant=NUM_PORTS-1, so port 0 wins first.
  - Memory contents are not reset (undefined).
- Grant (combinational from req_valid and last_grant)
  - At most one req_ready bit is high per cycle, and only for a port whose req_valid=1.
  - No request: req_ready=0 and the pointer holds.
- ARB_MODE=0: the winner is the first valid port scanning last_grant+1, last_grant+2, … modulo NUM_PORTS. On a transfer, last_grant becomes the winner.
- ARB_MODE=1: the lowest-index valid port wins; the pointer is unused.
- Requester rule: once req_valid rises, the requester holds valid and all request fields stable until its transfer. The block does not check this.
- Address decode
  - word = req_addr >> log2(DATA_WIDTH/8); the low byte-offset bits are ignored.
  - word ≥ MEM_SIZE, or any discarded upper address bit set: out of range.
- Transfer edge, in range
  - Write: each byte lane with wstrb=1 is updated; the other lanes are unchanged.
  - Read: the word value before any write on this edge is captured.
- Transfer edge, out of range: no memory update; rdata=0; err=1.
- Response, 1-cycle latency
  - The cycle after the transfer: resp_valid[winner]=1 and resp_err as decoded.
  - resp_rdata = read word; writes return the old word (read-before-write).
  - Otherwise resp_valid=0; resp_rdata and resp_err hold their last value.
- Throughput
  - Back-to-back grants are allowed every cycle; there is no dead cycle.
  - A port may be granted on consecutive cycles only if it is the sole requester (RR mode).
- Reset mid-operation: pending requests are dropped; there is no response for a transfer whose response cycle falls in reset.

Test Plan:
- Single port: port 0 writes 0x1122334455667788 to addr 0x40 (wstrb=0xFF), then reads 0x40. Required: read resp_valid[0] pulses one cycle after the grant; rdata=0x1122334455667788; err=0.
- RR fairness: all 4 ports hold valid, each for 2 transfers. Required: grant order 0,1,2,3,0,1,2,3, one grant per cycle, resp_valid one-hot and lagging by one cycle.
- RR with gaps: valid={1,0,1,0}, last_grant=0. Required: grant port 2, then port 0. Drop port 0 → port 2 is granted every cycle.
- Fixed priority (ARB_MODE=1): ports 1 and 3 both valid, each with 3 reads queued. Required: three consecutive grants to port 1, then port 3.
- Strobes / read-before-write: word holds 0xFFFF_FFFF_FFFF_FFFF; write 0 with wstrb=0x0F. Required: the write response returns 0xFFFF_FFFF_FFFF_FFFF; a later read returns 0xFFFF_FFFF_0000_0000.
- Error and reset
  - Read addr MEM_SIZE*8 → resp_err=1, rdata=0, memory unchanged.
  - Assert rst_n=0 in the cycle after a grant → no resp_valid; after release, port 0 is granted first.
